// File: rtl/final_clock_pkg.sv
// Shared definitions for the pulse-stretch block and the clock divider:
// FSM state encodings, default window/queue sizes, and the tick rate.
package final_clock_pkg;

  // Stretcher FSM states; the encodings are visible on debug_state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Default window lengths (in ticks) and queue depth.
  localparam int unsigned DEF_HOLD_TICKS = 8;
  localparam int unsigned DEF_GAP_TICKS  = 4;
  localparam int unsigned DEF_QDEPTH     = 7;
  localparam int unsigned DEF_CW         = 8;
  localparam int unsigned DEF_PW         = 3;

  // Rate of the tick strobe produced by the clock divider.
  localparam int unsigned TICK_HZ = 1000;

  // Counter reload value for a window of the given length. A window of
  // N ticks loads N-1 and leaves on the tick that finds the counter at 0.
  function automatic int unsigned reload_of(input int unsigned ticks);
    return (ticks == 0) ? 0 : ticks - 1;
  endfunction

endpackage

// File: rtl/final_tick_down.sv
// Loadable down-counter paced by the tick enable. Load wins over counting;
// the count stops at zero and never wraps. zero flags the final tick of
// a window.
module final_tick_down
  import final_clock_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic          zero
);

  logic [CW-1:0] count;

  // Reload on request, otherwise count down once per tick until zero.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/final_pulse_stretch.sv
// Pulse stretcher: turns one-cycle event pulses into a HOLD window of
// level_out=1 followed by a GAP window of level_out=0, both measured in
// ticks of an external time base. Pulses arriving while a window is in
// progress are counted in a saturating pending counter and replayed.
//
// All flops update on the falling clock edge, the same edge used by the
// input synchronisers feeding pulse_in.
//
// Handshake: none. pulse_in, tick and clear are single-cycle strobes
// sampled on every falling edge; there is no back-pressure, so a pulse
// that cannot be queued is dropped and recorded in the sticky overflow.
//
// Build option FINAL_STRETCH_RETRIGGER_EN: instead of queueing, a pulse
// during HOLD restarts the HOLD window and a pulse during GAP re-enters
// HOLD immediately; pending stays 0 and overflow never sets.
module final_pulse_stretch
  import final_clock_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS,
  parameter int unsigned QDEPTH     = DEF_QDEPTH,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned PW         = DEF_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pulse_in,
  input  logic          tick,
  input  logic          clear,
  output logic          level_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow,
  output logic [1:0]    debug_state
);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(reload_of(HOLD_TICKS));
  localparam logic [CW-1:0] GAP_LOAD  = CW'(reload_of(GAP_TICKS));
  localparam logic [PW-1:0] QMAX      = PW'(QDEPTH);

  state_t        state;
  state_t        nxt_state;
  logic [PW-1:0] nxt_pending;
  logic          nxt_overflow;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic          cnt_tick;
  logic          window_end;

  // Only windows consume ticks; a tick in IDLE does nothing.
  assign cnt_tick = tick && (state != ST_IDLE);

  final_tick_down #(
    .CW(CW)
  ) u_tick_down (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (cnt_tick),
    .zero     (cnt_zero)
  );

  // Next-state, counter reload and queue bookkeeping for the coming edge.
  always_comb begin
    nxt_state    = state;
    nxt_pending  = pending;
    nxt_overflow = overflow;
    cnt_load     = 1'b0;
    cnt_val      = HOLD_LOAD;
    window_end   = 1'b0;

    if (clear) begin
      // Flush everything; pulse_in and tick in this cycle are ignored.
      nxt_state    = ST_IDLE;
      nxt_pending  = '0;
      nxt_overflow = 1'b0;
      cnt_load     = 1'b1;
      cnt_val      = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Start a window on the sampling edge; a coincident tick is ignored.
          if (pulse_in) begin
            nxt_state = ST_HOLD;
            cnt_load  = 1'b1;
            cnt_val   = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (tick && cnt_zero) begin
            if (GAP_TICKS > 0) begin
              nxt_state = ST_GAP;
              cnt_load  = 1'b1;
              cnt_val   = GAP_LOAD;
            end else begin
              window_end = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tick && cnt_zero) begin
            window_end = 1'b1;
          end
        end
        default: begin
          nxt_state = ST_IDLE;
        end
      endcase

`ifdef FINAL_STRETCH_RETRIGGER_EN
      // Any pulse during a window restarts HOLD from its full length.
      if ((state != ST_IDLE) && pulse_in) begin
        nxt_state = ST_HOLD;
        cnt_load  = 1'b1;
        cnt_val   = HOLD_LOAD;
      end else if (window_end) begin
        nxt_state = ST_IDLE;
      end
`else
      if (window_end) begin
        // A pulse landing on the closing tick counts as queued, so it is
        // replayed even when the queue was empty. With a queued entry the
        // new pulse replaces the one consumed and pending is unchanged.
        if ((pending != '0) || pulse_in) begin
          nxt_state = ST_HOLD;
          cnt_load  = 1'b1;
          cnt_val   = HOLD_LOAD;
          if (!pulse_in) begin
            nxt_pending = pending - PW'(1);
          end
        end else begin
          nxt_state = ST_IDLE;
        end
      end else if ((state != ST_IDLE) && pulse_in) begin
        if (pending == QMAX) begin
          nxt_overflow = 1'b1;
        end else begin
          nxt_pending = pending + PW'(1);
        end
      end
`endif
    end
  end

  // State register with outputs registered alongside it.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      level_out <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= nxt_state;
      level_out <= (nxt_state == ST_HOLD);
      busy      <= (nxt_state != ST_IDLE);
      pending   <= nxt_pending;
      overflow  <= nxt_overflow;
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_final_pulse_stretch.sv
// Directed bench for final_pulse_stretch with HOLD_TICKS=3, GAP_TICKS=2,
// QDEPTH=2 and a tick every 4 clk. Inputs change on the rising edge; the
// DUT samples on the falling edge; outputs are read 1 time unit later.
module tb_final_pulse_stretch;
  import final_clock_pkg::*;

  localparam int unsigned HOLD = 3;
  localparam int unsigned GAP  = 2;
  localparam int unsigned QD   = 2;
  localparam int unsigned PW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pulse_in;
  logic          tick;
  logic          clear;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;
  logic [1:0]    debug_state;

  int checks = 0;
  int errors = 0;
  int cyc;
  int rises;
  int high_cnt;
  int gap_cnt;
  logic prev_level;

  final_pulse_stretch #(
    .HOLD_TICKS(HOLD),
    .GAP_TICKS (GAP),
    .QDEPTH    (QD),
    .CW        (8),
    .PW        (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .tick       (tick),
    .clear      (clear),
    .level_out  (level_out),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow),
    .debug_state(debug_state)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // Hold reset across a couple of cycles, then restart bookkeeping.
  task automatic start_test();
    rst_n = 1'b0; pulse_in = 1'b0; tick = 1'b0; clear = 1'b0;
    @(posedge clk);
    @(posedge clk);
    rst_n = 1'b1;
    cyc = 0; rises = 0; high_cnt = 0; gap_cnt = 0; prev_level = 1'b0;
  endtask

  // One clock cycle of stimulus; tick fires when cyc % 4 == 3.
  task automatic step(input logic p, input logic c);
    @(posedge clk);
    pulse_in = p;
    clear    = c;
    tick     = ((cyc % 4) == 3);
    @(negedge clk);
    #1;
    if (level_out && !prev_level) rises++;
    if (level_out) high_cnt++;
    if (busy && !level_out) gap_cnt++;
    prev_level = level_out;
    cyc++;
  endtask

  // Idle the inputs until busy drops; idle_cyc is the cycle that ended it.
  task automatic run_until_idle(input int budget, output int idle_cyc);
    int n;
    n = 0;
    idle_cyc = -1;
    while (busy && (n < budget)) begin
      step(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, budget);
    end else begin
      idle_cyc = cyc - 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse_in = 1'b0; tick = 1'b0; clear = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({level_out, busy, pending, overflow, debug_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: level=%0b busy=%0b pending=%0d ovf=%0b state=%0d, required all 0",
               level_out, busy, pending, overflow, debug_state);
    end
    start_test();
    // Ticks alone in IDLE must not start anything.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    checks++;
    if ({level_out, busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_tick: level=%0b busy=%0b, required 0 0", level_out, busy);
    end
  endtask

`ifndef FINAL_STRETCH_RETRIGGER_EN
  // One pulse: HOLD over cycles 0..10, GAP over 11..18, IDLE at 19.
  task automatic test_single();
    start_test();
    step(1'b1, 1'b0);
    checks++;
    if (level_out !== 1'b1 || busy !== 1'b1 || debug_state !== ST_HOLD) begin
      errors++;
      $display("FAIL single_rise: level=%0b busy=%0b state=%0d, required 1 1 1", level_out, busy, debug_state);
    end
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 1'b0);
      if (i == 10) begin
        checks++;
        if (level_out !== 1'b1) begin
          errors++;
          $display("FAIL single_hold_end: level=%0b at cycle 10, required 1", level_out);
        end
      end
      if (i == 11) begin
        checks++;
        if (level_out !== 1'b0 || debug_state !== ST_GAP) begin
          errors++;
          $display("FAIL single_gap_start: level=%0b state=%0d at cycle 11, required 0 2", level_out, debug_state);
        end
      end
      if (i == 18) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_gap_end: busy=%0b at cycle 18, required 1", busy);
        end
      end
      if (i == 19) begin
        checks++;
        if (busy !== 1'b0 || pending !== '0 || debug_state !== ST_IDLE) begin
          errors++;
          $display("FAIL single_idle: busy=%0b pending=%0d state=%0d at cycle 19, required 0 0 0",
                   busy, pending, debug_state);
        end
      end
    end
    checks++;
    if (rises !== 1 || high_cnt !== 11) begin
      errors++;
      $display("FAIL single_counts: rises=%0d high=%0d, required 1 11", rises, high_cnt);
    end
  endtask

  // Three pulses back to back: windows start at 0, 19, 39; idle at 59.
  task automatic test_back_to_back();
    int idle_cyc;
    start_test();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (pending !== 2'd1) begin
      errors++;
      $display("FAIL b2b_pending1: pending=%0d, required 1", pending);
    end
    step(1'b1, 1'b0);
    checks++;
    if (pending !== 2'd2) begin
      errors++;
      $display("FAIL b2b_pending2: pending=%0d, required 2", pending);
    end
    run_until_idle(200, idle_cyc);
    checks++;
    if (rises !== 3 || high_cnt !== 35 || gap_cnt !== 24 || idle_cyc !== 59) begin
      errors++;
      $display("FAIL b2b_windows: rises=%0d high=%0d gap=%0d idle_at=%0d, required 3 35 24 59",
               rises, high_cnt, gap_cnt, idle_cyc);
    end
    checks++;
    if (overflow !== 1'b0 || pending !== '0) begin
      errors++;
      $display("FAIL b2b_end: overflow=%0b pending=%0d, required 0 0", overflow, pending);
    end
  endtask

  // Five pulses: two queue, the last two are dropped and overflow sticks.
  task automatic test_overflow();
    int idle_cyc;
    start_test();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (pending !== 2'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: pending=%0d overflow=%0b, required 2 0", pending, overflow);
    end
    step(1'b1, 1'b0);
    checks++;
    if (pending !== 2'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: pending=%0d overflow=%0b, required 2 1", pending, overflow);
    end
    step(1'b1, 1'b0);
    run_until_idle(200, idle_cyc);
    checks++;
    if (rises !== 3 || idle_cyc !== 59 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_windows: rises=%0d idle_at=%0d overflow=%0b, required 3 59 1",
               rises, idle_cyc, overflow);
    end
    step(1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%0b, required 0", overflow);
    end
  endtask

  // Pulse on the closing GAP tick (cycle 19) with one entry queued.
  task automatic test_pulse_at_gap_end();
    int idle_cyc;
    start_test();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 2; i <= 18; i++) step(1'b0, 1'b0);
    checks++;
    if (debug_state !== ST_GAP || pending !== 2'd1) begin
      errors++;
      $display("FAIL gapend_pre: state=%0d pending=%0d, required 2 1", debug_state, pending);
    end
    step(1'b1, 1'b0);
    checks++;
    if (debug_state !== ST_HOLD || level_out !== 1'b1 || pending !== 2'd1) begin
      errors++;
      $display("FAIL gapend_hold: state=%0d level=%0b pending=%0d, required 1 1 1",
               debug_state, level_out, pending);
    end
    run_until_idle(200, idle_cyc);
    checks++;
    if (rises !== 3 || idle_cyc !== 59) begin
      errors++;
      $display("FAIL gapend_windows: rises=%0d idle_at=%0d, required 3 59", rises, idle_cyc);
    end
  endtask

  // clear together with pulse_in mid-HOLD, with a full queue and overflow set.
  task automatic test_clear();
    start_test();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (pending !== 2'd2 || overflow !== 1'b1 || level_out !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre: pending=%0d overflow=%0b level=%0b, required 2 1 1",
               pending, overflow, level_out);
    end
    step(1'b1, 1'b1);
    checks++;
    if ({level_out, busy, pending, overflow, debug_state} !== '0) begin
      errors++;
      $display("FAIL clear_flush: level=%0b busy=%0b pending=%0d ovf=%0b state=%0d, required all 0",
               level_out, busy, pending, overflow, debug_state);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    checks++;
    if (level_out !== 1'b0 || busy !== 1'b0 || rises !== 1) begin
      errors++;
      $display("FAIL clear_ignored_pulse: level=%0b busy=%0b rises=%0d, required 0 0 1",
               level_out, busy, rises);
    end
  endtask
`else
  // A pulse on HOLD tick 2 restarts HOLD: 5 ticks high, then GAP pulse re-enters HOLD.
  task automatic test_retrigger();
    int idle_cyc;
    start_test();
    step(1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (level_out !== 1'b1 || pending !== '0) begin
      errors++;
      $display("FAIL retrig_reload: level=%0b pending=%0d, required 1 0", level_out, pending);
    end
    for (int i = 8; i <= 18; i++) step(1'b0, 1'b0);
    checks++;
    if (level_out !== 1'b1) begin
      errors++;
      $display("FAIL retrig_extended: level=%0b at cycle 18, required 1", level_out);
    end
    step(1'b0, 1'b0);
    checks++;
    if (level_out !== 1'b0 || debug_state !== ST_GAP || high_cnt !== 19) begin
      errors++;
      $display("FAIL retrig_gap: level=%0b state=%0d high=%0d, required 0 2 19",
               level_out, debug_state, high_cnt);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (level_out !== 1'b1 || debug_state !== ST_HOLD || pending !== '0) begin
      errors++;
      $display("FAIL retrig_gap_pulse: level=%0b state=%0d pending=%0d, required 1 1 0",
               level_out, debug_state, pending);
    end
    run_until_idle(200, idle_cyc);
    checks++;
    if (rises !== 2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL retrig_end: rises=%0d overflow=%0b, required 2 0", rises, overflow);
    end
  endtask
`endif

  // Asynchronous reset between edges, mid-GAP and mid-HOLD.
  task automatic test_async_reset();
    start_test();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 2; i <= 12; i++) step(1'b0, 1'b0);
    checks++;
    if (debug_state !== ST_GAP || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: state=%0d busy=%0b, required 2 1", debug_state, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({level_out, busy, pending, overflow, debug_state} !== '0) begin
      errors++;
      $display("FAIL areset_gap: level=%0b busy=%0b pending=%0d ovf=%0b state=%0d, required all 0",
               level_out, busy, pending, overflow, debug_state);
    end
    start_test();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (level_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_hold: level=%0b busy=%0b, required 0 0", level_out, busy);
    end
  endtask

  initial begin
    test_reset();
`ifndef FINAL_STRETCH_RETRIGGER_EN
    test_single();
    test_back_to_back();
    test_overflow();
    test_pulse_at_gap_end();
    test_clear();
`else
    test_retrigger();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
